// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: datapath width, ALU opcodes, FSM state codes.
package alu_arbiter_pkg;

   localparam int unsigned WIDTH_DEF = 8;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_SHL = 2'b10;
   localparam logic [1:0] ALU_AND = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_EXEC = 2'b01;
   localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Combinational 2-way round-robin selector: on a tie the requester that was
// not granted last wins, otherwise the sole requester wins.
module rr_pick2
   import alu_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic [0:0] last,
   output logic [1:0] gnt,
   output logic       gnt_idx
);

   // Pick the winner index, then expand to a one-hot (or zero) grant
   always_comb begin
      gnt     = '0;
      gnt_idx = 1'b0;
      if (req == 2'b11) begin
         gnt_idx = ~last[0];
      end else begin
         gnt_idx = req[1];
      end
      if (|req) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, one
// operation at a time, in round-robin order (IDLE -> EXEC -> RESP).
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [1:0]       req_op0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   input  logic [1:0]       req_op1,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_res
);

   logic [1:0]       r_state;
   logic [0:0]       r_last;
   logic             r_owner;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_data;

   logic [1:0]       w_gnt;
   logic             w_gnt_idx;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [1:0]       w_op;

   rr_pick2 u_pick (
      .req     (req_valid),
      .last    (r_last),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx)
   );

   // Operand/opcode of whichever requester currently wins arbitration
   always_comb begin
      w_a  = w_gnt_idx ? req_a1  : req_a0;
      w_b  = w_gnt_idx ? req_b1  : req_b0;
      w_op = w_gnt_idx ? req_op1 : req_op0;
   end

   // FSM, operand registers and held response register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;
         r_owner <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= ALU_ADD;
         r_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|req_valid) begin
                  r_a     <= w_a;
                  r_b     <= w_b;
                  r_op    <= w_op;
                  r_owner <= w_gnt_idx;
                  r_last  <= w_gnt_idx;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_data  <= alu_res;
               r_state <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready[r_owner]) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Handshake outputs: grants only in IDLE, response valid only in RESP
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (r_state == ST_IDLE) begin
         req_ready = w_gnt;
      end
      if (r_state == ST_RESP) begin
         rsp_valid[r_owner] = 1'b1;
      end
   end

   assign rsp_data = r_data;
   assign alu_a    = r_a;
   assign alu_b    = r_b;
   assign alu_op   = r_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: acts as the parent with its own ALU,
// drives directed and random transactions, and checks against a
// transaction-level reference model.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [7:0] req_a0, req_b0, req_a1, req_b1;
   logic [1:0] req_op0, req_op1;
   logic [1:0] rsp_valid;
   logic [1:0] rsp_ready;
   logic [7:0] rsp_data;
   logic [7:0] alu_a, alu_b, alu_res;
   logic [1:0] alu_op;

   int n_checks = 0;
   int n_errors = 0;
   int m_last   = 1;

   alu_arbiter #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a0    (req_a0),
      .req_b0    (req_b0),
      .req_op0   (req_op0),
      .req_a1    (req_a1),
      .req_b1    (req_b1),
      .req_op1   (req_op1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_res   (alu_res)
   );

   always #5 clk = ~clk;

   // The shared ALU that sits beside the arbiter in the parent
   always_comb begin
      case (alu_op)
         2'b00:   alu_res = alu_a + alu_b;
         2'b01:   alu_res = alu_a - alu_b;
         2'b10:   alu_res = (alu_a >= 8'd8) ? 8'h00 : (alu_b << alu_a);
         default: alu_res = alu_a & alu_b;
      endcase
   end

   function automatic int ref_res(input int a, input int b, input int op);
      case (op)
         0:       return (a + b) % 256;
         1:       return (a - b + 256) % 256;
         2:       return (a >= 8) ? 0 : (b * (1 << a)) % 256;
         default: return a & b;
      endcase
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_reqs();
      req_a0  = 8'($urandom);
      req_b0  = 8'($urandom);
      req_op0 = 2'($urandom);
      req_a1  = 8'($urandom);
      req_b1  = 8'($urandom);
      req_op1 = 2'($urandom);
   endtask

   // One full operation starting in an IDLE cycle; v must be non-zero
   task automatic do_txn(input logic [1:0] v,
                         input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] op0,
                         input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] op1,
                         input int hold, input logic [1:0] v_after, input logic rnd_ops);
      int g, ea, eb, eop, er;
      logic [1:0] rr;
      if (v == 2'b11) g = 1 - m_last;
      else if (v == 2'b01) g = 0;
      else g = 1;
      m_last = g;
      ea  = (g == 0) ? a0  : a1;
      eb  = (g == 0) ? b0  : b1;
      eop = (g == 0) ? op0 : op1;
      er  = ref_res(ea, eb, eop);

      req_valid = v;
      req_a0 = a0; req_b0 = b0; req_op0 = op0;
      req_a1 = a1; req_b1 = b1; req_op1 = op1;
      rsp_ready = 2'($urandom);
      #1;
      check("accept_req_ready", req_ready, 1 << g);
      check("accept_rsp_valid", rsp_valid, 0);
      step();

      req_valid = v_after;
      if (rnd_ops) scramble_reqs();
      #1;
      check("exec_alu_a", alu_a, ea);
      check("exec_alu_b", alu_b, eb);
      check("exec_alu_op", alu_op, eop);
      check("exec_req_ready", req_ready, 0);
      check("exec_rsp_valid", rsp_valid, 0);
      step();

      for (int i = 0; i <= hold; i++) begin
         rr = 2'($urandom);
         rr[g] = (i == hold);
         rsp_ready = rr;
         #1;
         check("resp_rsp_valid", rsp_valid, 1 << g);
         check("resp_rsp_data", rsp_data, er);
         check("resp_req_ready", req_ready, 0);
         check("resp_alu_a_held", alu_a, ea);
         check("resp_alu_op_held", alu_op, eop);
         step();
         if (rnd_ops) scramble_reqs();
      end

      req_valid = 2'b00;
      rsp_ready = 2'b00;
      #1;
      check("done_rsp_valid", rsp_valid, 0);
      check("done_req_ready", req_ready, 0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      step();
      step();
      rst = 1'b0;
      m_last = 1;
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_alu_op", alu_op, 0);
   endtask

   initial begin
      logic [1:0] v, va;
      rst = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_a0 = '0; req_b0 = '0; req_op0 = '0;
      req_a1 = '0; req_b1 = '0; req_op1 = '0;
      #1;
      apply_reset();

      // Single requester add
      do_txn(2'b01, 8'd5, 8'd3, 2'b00, 8'd0, 8'd0, 2'b00, 0, 2'b00, 1'b0);

      // Tie right after reset: req0 first, then alternation
      apply_reset();
      do_txn(2'b11, 8'd3, 8'd5, 2'b01, 8'd3, 8'd1, 2'b10, 0, 2'b11, 1'b0);
      do_txn(2'b11, 8'd3, 8'd5, 2'b01, 8'd3, 8'd1, 2'b10, 1, 2'b11, 1'b0);
      do_txn(2'b11, 8'd3, 8'd5, 2'b01, 8'd3, 8'd1, 2'b10, 0, 2'b11, 1'b0);
      do_txn(2'b11, 8'd3, 8'd5, 2'b01, 8'd3, 8'd1, 2'b10, 0, 2'b11, 1'b0);

      // Backpressure with req0 waiting, then req0 accepted right after
      do_txn(2'b10, 8'h11, 8'h22, 2'b00, 8'hF0, 8'h3C, 2'b11, 4, 2'b01, 1'b0);
      do_txn(2'b01, 8'h11, 8'h22, 2'b00, 8'hF0, 8'h3C, 2'b11, 0, 2'b00, 1'b0);

      // Reset during EXEC abandons the operation
      req_valid = 2'b01;
      req_a0 = 8'hFF; req_b0 = 8'h01; req_op0 = 2'b00;
      #1;
      check("mid_accept", req_ready, 2'b01);
      step();
      rst = 1'b1;
      req_valid = 2'b00;
      step();
      rst = 1'b0;
      m_last = 1;
      #1;
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_rsp_data", rsp_data, 0);
      check("mid_rst_alu_a", alu_a, 0);
      check("mid_rst_req_ready", req_ready, 0);
      for (int i = 0; i < 3; i++) begin
         rsp_ready = 2'b11;
         step();
         check("mid_rst_no_rsp", rsp_valid, 0);
      end
      rsp_ready = 2'b00;

      // Wrap and shift boundary
      do_txn(2'b01, 8'hFF, 8'h02, 2'b00, 8'd0, 8'd0, 2'b00, 0, 2'b00, 1'b0);
      do_txn(2'b01, 8'd8, 8'hFF, 2'b10, 8'd0, 8'd0, 2'b00, 0, 2'b00, 1'b0);

      // Single-valid precedence: req1 twice back to back
      do_txn(2'b10, 8'd0, 8'd0, 2'b00, 8'd7, 8'd9, 2'b00, 0, 2'b10, 1'b0);
      do_txn(2'b10, 8'd0, 8'd0, 2'b00, 8'd2, 8'd9, 2'b01, 0, 2'b00, 1'b0);

      // Idle cycles with no requests stay idle
      for (int i = 0; i < 2; i++) begin
         step();
         check("idle_req_ready", req_ready, 0);
         check("idle_rsp_valid", rsp_valid, 0);
      end

      // Randomized traffic
      for (int t = 0; t < 150; t++) begin
         v  = 2'($urandom_range(1, 3));
         va = 2'($urandom);
         do_txn(v, 8'($urandom), 8'($urandom), 2'($urandom),
                8'($urandom), 8'($urandom), 2'($urandom),
                int'($urandom_range(0, 3)), va, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 8-bit combinational ALU between two requesters: the fetch/PC-update path (port 0) and the execute/writeback path (port 1).
Each requester has a valid/ready request channel and a valid/ready response channel. Requesters are served in round-robin order, one operation at a time.
The block drives the ALU operand and opcode inputs from registers and captures the ALU result into a held response register.

Parameters:
WIDTH, 8, operand and result width; must match the ALU datapath width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  2  per-requester request valid (bit i = requester i)
req_ready  out  2  per-requester request accepted this cycle
req_a0, req_b0  in  WIDTH each  requester 0 operands
req_op0  in  2  requester 0 opcode
req_a1, req_b1  in  WIDTH each  requester 1 operands
req_op1  in  2  requester 1 opcode
rsp_valid  out  2  per-requester response valid
rsp_ready  in  2  per-requester response consumed
rsp_data  out  WIDTH  result; valid only when a rsp_valid bit is high
alu_a, alu_b  out  WIDTH each  registered operands to ALU
alu_op  out  2  registered opcode to ALU (00 add, 01 sub a-b, 10 b<<a, 11 and)
alu_res  in  WIDTH  combinational ALU result

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, last_grant=1 (so requester 0 wins the first tie), req_ready=00, rsp_valid=00, rsp_data=0, alu_a=0, alu_b=0, alu_op=00.
- FSM states:
  - IDLE: grant = round-robin pick among the req_valid bits. req_ready[grant] is high combinationally in this state only; every other req_ready bit is low. If any valid is present, latch a/b/op of the granted requester into alu_a/alu_b/alu_op, record owner=grant and last_grant=grant, then go to EXEC. With no valid request, stay in IDLE.
  - EXEC: exactly one cycle with the operands stable on the ALU. At the end of the cycle, capture alu_res into rsp_data and go to RESP.
  - RESP: rsp_valid[owner] is high; rsp_data and alu_* are held stable. When rsp_ready[owner] is high, the response completes and the FSM goes to IDLE. The other rsp_ready bit is ignored. req_ready is 00.
- Latency: request acceptance in cycle N gives EXEC in N+1 and rsp_valid from N+2. Minimum occupancy is 3 cycles per operation; there is no pipelining or overlap.
- Round-robin rule: when both requests are valid, grant the requester that is not last_grant. When only one is valid, grant it regardless of last_grant.
- Width rules: results are modulo 2^WIDTH, and the block does no checking. Sub wraps (3-5 = 0xFE). Shift amounts of WIDTH or more yield 0; this comes from the ALU and passes through unmodified.
- Requester contract: a requester must hold valid, operands and op stable until accepted. Deasserting valid before acceptance is legal; the request is simply not seen.
- Backpressure: RESP holds indefinitely while rsp_ready[owner] is low. No new request is accepted in the meantime.
- Reset mid-operation: rst in EXEC or RESP abandons the in-flight operation. No response is ever delivered for it, and all outputs return to their reset values the next cycle.
- Invariants: at most one req_ready bit is high, at most one rsp_valid bit is high, and req_ready and rsp_valid are never non-zero in the same cycle.

Decomposition:
- Shared package: ALU opcode constants (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_SHL=2'b10, ALU_AND=2'b11), FSM state encoding (IDLE, EXEC, RESP), and the WIDTH default.
- Sub-module rr_pick2: a combinational 2-way round-robin selector. Inputs are req[1:0] and last[0:0]; outputs are gnt[1:0] (one-hot or zero) and gnt_idx.
- The FSM, operand registers and response register stay in alu_arbiter.
- The ALU is instantiated by the parent alongside this block, not inside it.

Test Plan:
- Single requester: after reset, req0 add a=5 b=3 -> req_ready=01 in the same cycle, alu_op=00 in EXEC, rsp_valid=01 two cycles later with rsp_data=0x08; with rsp_ready=01 the FSM returns to IDLE.
- Tie and fairness: both valid right after reset with req0 sub 3,5 and req1 shl a=3 b=1 -> req0 served first with 0xFE, then req1 with 0x08. Repeating the tie with both valid gives order 1,0 alternation thereafter.
- Backpressure: req1 and a=0xF0 b=0x3C, rsp_ready held 0 for 4 cycles -> rsp_valid=10 and rsp_data=0x30 stable for all 4 cycles; req0 held valid sees req_ready[0]=0 throughout and is accepted only in the IDLE cycle after rsp_ready[1]=1.
- Reset mid-operation: assert rst during EXEC of req0 add 0xFF+0x01 -> next cycle rsp_valid=00, rsp_data=0, state IDLE; no response is ever emitted for that operation.
- Wrap and shift boundary: req0 add 0xFF+0x02 -> 0x01; req0 shl a=8 b=0xFF -> 0x00.
- Single-valid precedence: req1 alone valid immediately after a req1 grant -> req1 is granted again with no idle bubble beyond the mandatory IDLE cycle.
